operand_entry: RTL

Digit-accumulation front end of the calculator operand path. Accepts decoded keypad codes one at a time and builds an unsigned decimal operand (value*10 + digit). On ENTER it presents the finished operand with a one-cycle write strobe to the downstream operand register (`dff_nbits`: `d_i`, `we_i`). It also handles clear, backspace and overflow, with a ready handshake toward the keypad decoder.

---
 rtl/operand_entry_if.sv | 22 ++
 rtl/operand_entry.sv | 115 +++++++++++
 2 files changed

// File: rtl/operand_entry_if.sv
// rtl/operand_entry_if.sv - keypad-side and operand-register-side signals of operand_entry
interface operand_entry_if #(
   parameter int width = 8
);
   logic             key_valid_i;
   logic [3:0]       key_code_i;
   logic             key_ready_o;
   logic [width-1:0] value_o;
   logic [width-1:0] d_o;
   logic             we_o;
   logic             overflow_o;

   modport master (
      output key_valid_i, key_code_i,
      input  key_ready_o, value_o, d_o, we_o, overflow_o
   );

   modport slave (
      input  key_valid_i, key_code_i,
      output key_ready_o, value_o, d_o, we_o, overflow_o
   );
endinterface

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - decimal operand accumulator with clear, backspace, overflow and commit strobe
module operand_entry #(
   parameter int width = 8
) (
   input  logic           clock_i,
   input  logic           reset_i,
   operand_entry_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ENTRY, COMMIT, ERROR} state_t;

   localparam logic [3:0] KEY_ENTER = 4'd10;
   localparam logic [3:0] KEY_CLEAR = 4'd11;
   localparam logic [3:0] KEY_BACK  = 4'd12;

   state_t           state_q, state_d;
   logic [width-1:0] value_q, value_d;
   logic [width-1:0] d_q, d_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             we_q, we_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, ready_d;

   logic             accept;
   logic             is_digit;
   logic [width+3:0] prod;

   assign accept   = bus.key_valid_i && ready_q;
   assign is_digit = (bus.key_code_i <= 4'd9);
   // Four guard bits are enough: value*10+9 < 16*2^width.
   assign prod     = (width+4)'(value_q) * (width+4)'(10) + (width+4)'(bus.key_code_i);

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      ovf_d   = ovf_q;
      if (state_q == COMMIT) begin
         value_d = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end else if (accept) begin
         unique case (state_q)
            IDLE: begin
               if (is_digit) begin
                  value_d = width'(bus.key_code_i);
                  cnt_d   = 4'd1;
                  state_d = ENTRY;
               end
            end
            ENTRY: begin
               if (is_digit) begin
                  if (prod[width+3:width] != 4'd0) begin
                     ovf_d   = 1'b1;
                     state_d = ERROR;
                  end else begin
                     value_d = prod[width-1:0];
                     cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                  end
               end else if (bus.key_code_i == KEY_BACK) begin
                  value_d = value_q / width'(10);
                  cnt_d   = cnt_q - 4'd1;
                  if (cnt_q == 4'd1) state_d = IDLE;
               end else if (bus.key_code_i == KEY_CLEAR) begin
                  value_d = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else if (bus.key_code_i == KEY_ENTER) begin
                  d_d     = value_q;
                  we_d    = 1'b1;
                  state_d = COMMIT;
               end
            end
            ERROR: begin
               if (bus.key_code_i == KEY_CLEAR) begin
                  ovf_d   = 1'b0;
                  value_d = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      ready_d = (state_d != COMMIT);
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         value_q <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
      end
   end

   // Ready is masked while reset is held so the keypad never sees a handshake mid-reset.
   assign bus.key_ready_o = ready_q && reset_i;
   assign bus.value_o     = value_q;
   assign bus.d_o         = d_q;
   assign bus.we_o        = we_q;
   assign bus.overflow_o  = ovf_q;
endmodule
